mosi_cmd_sequencer: RTL and testbench
=====================================

MOSI_CMD_SEQUENCER -- requirements
Module: mosi_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, command RAM address width (1024 entries).
REQ-002 SHALL have parameter DATA_W, default 16, command word width.
REQ-003 SHALL have port dataclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  level; high = run sequence, low = stop.
REQ-006 SHALL have port loop_mode  input  1  1 = wrap to index 0 after max_index; 0 = single pass.
REQ-007 SHALL have port max_index  input  ADDR_W  last command index of a pass, latched at pass start.
REQ-008 SHALL have port cmd_req  input  1  one-cycle request from SPI engine for next command.
REQ-009 SHALL have port RAM_addr_B  output  ADDR_W  read address to command RAM port B.
REQ-010 SHALL have port RAM_data_out_B  input  DATA_W  RAM port B data, valid one cycle after address.
REQ-011 SHALL have port cmd_word  output  DATA_W  registered command delivered to SPI engine.
REQ-012 SHALL have port cmd_index  output  ADDR_W  index of the current cmd_word.
REQ-013 SHALL have port cmd_valid  output  1  one-cycle strobe qualifying cmd_word/cmd_index.
REQ-014 SHALL have port pass_done  output  1  one-cycle strobe with cmd_valid of the last index.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE and DONE.
REQ-016 SHALL have port req_overrun  output  1  sticky flag: cmd_req arrived while a fetch was in flight.

Function
REQ-017 SHALL implement states IDLE, WAIT, READ, CAPT, DONE.
REQ-018 IDLE -> WAIT when enable=1; index <= 0, max latch <= max_index.
REQ-019 WAIT: cmd_req=1 -> READ; enable=0 (and no cmd_req) -> IDLE; otherwise stay.
REQ-020 READ -> CAPT unconditionally; RAM_addr_B equals index throughout READ.
REQ-021 CAPT -> on exit edge: cmd_word <= RAM_data_out_B, cmd_index <= index, cmd_valid <= 1.
REQ-022 Latency SHALL be exactly 3 cycles: cmd_req sampled at edge k -> cmd_valid high in the cycle after edge k+2.
REQ-023 CAPT with index<max latch: index <= index+1; next state WAIT if enable=1, else IDLE.
REQ-024 CAPT with index==max latch: pass_done=1 with cmd_valid; loop_mode=1 and enable=1 -> index <= 0, re-latch max_index, WAIT; loop_mode=0 -> DONE; enable=0 -> IDLE.
REQ-025 DONE SHALL hold until enable=0, then IDLE; cmd_req in DONE ignored, no strobe.
REQ-026 enable falling in READ/CAPT SHALL NOT abort; the in-flight command is delivered first.
REQ-027 max_index changes mid-pass SHALL take effect only at next pass start.
REQ-028 max_index=0 SHALL give one-command passes, pass_done with every cmd_valid.
REQ-029 RAM_addr_B SHALL always equal index register; index wraps only via REQ-024, never by overflow.
REQ-030 cmd_word/cmd_index SHALL hold last value between strobes.

Reset
REQ-031 reset=1 SHALL force IDLE within one edge, overriding all inputs, including mid-fetch.
REQ-032 Reset values: cmd_word=0, cmd_index=0, RAM_addr_B=0, cmd_valid=0, pass_done=0, busy=0, req_overrun=0, max latch=0.

Configuration
REQ-033 Macro SEQ_OVERRUN_DETECT_EN defined: req_overrun sets when cmd_req=1 in READ or CAPT, the request is dropped, flag clears only on reset or IDLE->WAIT.
REQ-034 Macro undefined: req_overrun tied to 0, no detection logic; cmd_req in READ/CAPT silently dropped.

Verification
REQ-035 RAM[0..3]=16'hA000..A003, max_index=3, loop_mode=0, enable=1, 4 spaced cmd_req -> cmd_word A000..A003, cmd_index 0..3, pass_done with A003, state DONE, busy=0.
REQ-036 Same, loop_mode=1, 6 cmd_req -> indices 0,1,2,3,0,1; pass_done once at index 3.
REQ-037 cmd_req at edge k -> cmd_valid exactly in cycle after edge k+2; RAM_addr_B stable through READ.
REQ-038 SEQ_OVERRUN_DETECT_EN defined, cmd_req in two consecutive cycles -> one cmd_valid, req_overrun=1 until next IDLE->WAIT; undefined -> req_overrun stays 0.
REQ-039 enable dropped in READ -> command still delivered, then IDLE; reset asserted in CAPT -> no cmd_valid, all outputs at reset values next cycle.
REQ-040 max_index changed 3->1 mid-pass, loop_mode=1 -> current pass ends at 3, next pass ends at 1.

Source files
------------

// File: rtl/mosi_cmd_sequencer_if.sv
// Command-fetch bus: SPI-engine request/strobe side plus command RAM port B.
// master = sequencer, slave = SPI engine and RAM model.
interface mosi_cmd_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              cmd_req;
  logic [ADDR_W-1:0] RAM_addr_B;
  logic [DATA_W-1:0] RAM_data_out_B;
  logic [DATA_W-1:0] cmd_word;
  logic [ADDR_W-1:0] cmd_index;
  logic              cmd_valid;
  logic              pass_done;

  modport master (
    input  cmd_req, RAM_data_out_B,
    output RAM_addr_B, cmd_word, cmd_index, cmd_valid, pass_done
  );

  modport slave (
    output cmd_req, RAM_data_out_B,
    input  RAM_addr_B, cmd_word, cmd_index, cmd_valid, pass_done
  );
endinterface

// File: rtl/mosi_cmd_sequencer.sv
// Walks command RAM on each cmd_req; cmd_valid 3 cycles after the request, no backpressure.
// Requests during a fetch are dropped; SEQ_OVERRUN_DETECT_EN adds the sticky req_overrun flag.
module mosi_cmd_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic                  dataclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  loop_mode,
  input  logic [ADDR_W-1:0]     max_index,
  output logic                  busy,
  output logic                  req_overrun,
  mosi_cmd_sequencer_if.master  bus
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_CAPT, S_DONE} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] max_lat;
  logic [DATA_W-1:0] cmd_word_q;
  logic [ADDR_W-1:0] cmd_index_q;
  logic              cmd_valid_q;
  logic              pass_done_q;
  logic              last;

  assign last = (index == max_lat);

  always_ff @(posedge dataclk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (enable) next_state = S_WAIT;
      S_WAIT: begin
        if (bus.cmd_req)  next_state = S_READ;
        else if (!enable) next_state = S_IDLE;
      end
      S_READ: next_state = S_CAPT;
      S_CAPT: begin
        if (!enable)        next_state = S_IDLE;
        else if (!last)     next_state = S_WAIT;
        else if (loop_mode) next_state = S_WAIT;
        else                next_state = S_DONE;
      end
      S_DONE: if (!enable) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
  end

  // Capture happens on the CAPT exit edge; RAM data has been valid since READ's edge.
  always_ff @(posedge dataclk) begin
    if (reset) begin
      index       <= '0;
      max_lat     <= '0;
      cmd_word_q  <= '0;
      cmd_index_q <= '0;
      cmd_valid_q <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      pass_done_q <= 1'b0;
      if (state == S_IDLE && enable) begin
        index   <= '0;
        max_lat <= max_index;
      end
      if (state == S_CAPT) begin
        cmd_word_q  <= bus.RAM_data_out_B;
        cmd_index_q <= index;
        cmd_valid_q <= 1'b1;
        pass_done_q <= last;
        if (!last) begin
          index <= index + ADDR_W'(1);
        end else if (loop_mode && enable) begin
          index   <= '0;
          max_lat <= max_index;
        end
      end
    end
  end

`ifdef SEQ_OVERRUN_DETECT_EN
  always_ff @(posedge dataclk) begin
    if (reset)
      req_overrun <= 1'b0;
    else if (state == S_IDLE && enable)
      req_overrun <= 1'b0;
    else if (bus.cmd_req && (state == S_READ || state == S_CAPT))
      req_overrun <= 1'b1;
  end
`else
  assign req_overrun = 1'b0;
`endif

  assign bus.RAM_addr_B = index;
  assign bus.cmd_word   = cmd_word_q;
  assign bus.cmd_index  = cmd_index_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.pass_done  = pass_done_q;

endmodule

// File: tb/tb_mosi_cmd_sequencer.sv
// Self-checking bench: scenario table plus hand sequences, scoreboard of expected commands.
module tb_mosi_cmd_sequencer;
  localparam int AW = 10;
  localparam int DW = 16;
`ifdef SEQ_OVERRUN_DETECT_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic          dataclk = 1'b0;
  logic          reset;
  logic          enable;
  logic          loop_mode;
  logic [AW-1:0] max_index;
  logic          busy;
  logic          req_overrun;

  mosi_cmd_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mosi_cmd_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .dataclk     (dataclk),
    .reset       (reset),
    .enable      (enable),
    .loop_mode   (loop_mode),
    .max_index   (max_index),
    .busy        (busy),
    .req_overrun (req_overrun),
    .bus         (bus)
  );

  always #5 dataclk = ~dataclk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge dataclk) bus.RAM_data_out_B <= ram[bus.RAM_addr_B];

  typedef struct {
    int            idx;
    logic [DW-1:0] word;
    bit            pd;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    bit loop;
    int max;
    int nreq;
    bit exp_busy;
    int exp_pd;
  } vec_t;
  vec_t vecs[4];

  int passed = 0;
  int total  = 0;
  int pd_count;
  int m_idx, m_max;
  bit m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Reference model of the pass walk, advanced once per request the bench issues.
  task automatic model_req(output bit deliver, output int idx);
    exp_t e;
    deliver = !m_done;
    idx     = m_idx;
    if (deliver) begin
      e.idx  = m_idx;
      e.word = ram[m_idx];
      e.pd   = (m_idx == m_max);
      exp_q.push_back(e);
      if (m_idx == m_max) begin
        if (loop_mode) begin
          m_idx = 0;
          m_max = int'(max_index);
        end else begin
          m_done = 1'b1;
        end
      end else begin
        m_idx++;
      end
    end
  endtask

  always @(negedge dataclk) begin
    exp_t e;
    if (!reset) begin
      if (bus.cmd_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_with_empty_queue", bus.cmd_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("cmd_word", bus.cmd_word, e.word);
          check("cmd_index", bus.cmd_index, e.idx);
          check("pass_done", bus.pass_done, e.pd);
          if (bus.pass_done) pd_count++;
        end
      end else begin
        check("pd_without_valid", bus.pass_done, 0);
      end
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    bus.cmd_req = 1'b0;
    repeat (2) @(posedge dataclk);
    #1 reset = 1'b0;
    exp_q.delete();
    pd_count = 0;
  endtask

  task automatic start_pass();
    enable = 1'b1;
    @(posedge dataclk);
    #1;
    m_idx  = 0;
    m_max  = int'(max_index);
    m_done = 1'b0;
  endtask

  task automatic issue_req();
    bit d;
    int i;
    model_req(d, i);
    @(posedge dataclk); #1 bus.cmd_req = 1'b1;
    @(posedge dataclk); #1 bus.cmd_req = 1'b0;
    if (d) begin
      check("addr_in_read", bus.RAM_addr_B, i);
      check("valid_early", bus.cmd_valid, 0);
    end
    @(posedge dataclk); #1;
    if (d) check("addr_in_capt", bus.RAM_addr_B, i);
    @(posedge dataclk); #1;
    check("latency_valid", bus.cmd_valid, d);
    @(posedge dataclk); #1;
  endtask

  initial begin
    bit d;
    int i;
    for (int k = 0; k < (1 << AW); k++) ram[k] = 16'hA000 + k[15:0];
    loop_mode = 1'b0;
    max_index = '0;

    vecs[0] = '{loop: 1'b0, max: 3, nreq: 4, exp_busy: 1'b0, exp_pd: 1};
    vecs[1] = '{loop: 1'b1, max: 3, nreq: 6, exp_busy: 1'b1, exp_pd: 1};
    vecs[2] = '{loop: 1'b0, max: 0, nreq: 2, exp_busy: 1'b0, exp_pd: 1};
    vecs[3] = '{loop: 1'b1, max: 0, nreq: 3, exp_busy: 1'b1, exp_pd: 3};

    do_reset();
    check("rst_cmd_word", bus.cmd_word, 0);
    check("rst_cmd_index", bus.cmd_index, 0);
    check("rst_addr", bus.RAM_addr_B, 0);
    check("rst_valid", bus.cmd_valid, 0);
    check("rst_pass_done", bus.pass_done, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", req_overrun, 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      loop_mode = vecs[v].loop;
      max_index = AW'(vecs[v].max);
      start_pass();
      check("busy_in_wait", busy, 1);
      for (int r = 0; r < vecs[v].nreq; r++) issue_req();
      repeat (2) @(posedge dataclk);
      #1;
      check("vec_busy_end", busy, vecs[v].exp_busy);
      check("vec_pd_count", pd_count, vecs[v].exp_pd);
      check("vec_queue_drained", exp_q.size(), 0);
    end

    // max_index change mid-pass only applies from the next pass
    do_reset();
    loop_mode = 1'b1;
    max_index = AW'(3);
    start_pass();
    repeat (2) issue_req();
    max_index = AW'(1);
    repeat (5) issue_req();
    check("maxchg_pd_count", pd_count, 2);
    check("maxchg_queue_drained", exp_q.size(), 0);

    // back-to-back requests: second lands in READ and is dropped
    do_reset();
    loop_mode = 1'b0;
    max_index = AW'(3);
    start_pass();
    model_req(d, i);
    @(posedge dataclk); #1 bus.cmd_req = 1'b1;
    @(posedge dataclk); #1;
    @(posedge dataclk); #1 bus.cmd_req = 1'b0;
    repeat (3) @(posedge dataclk);
    #1;
    check("ovr_flag", req_overrun, OV);
    check("ovr_single_delivery", exp_q.size(), 0);
    enable = 1'b0;
    @(posedge dataclk); #1;
    check("ovr_flag_in_idle", req_overrun, OV);
    enable = 1'b1;
    @(posedge dataclk); #1;
    check("ovr_cleared_on_start", req_overrun, 0);

    // enable dropped during READ still delivers, then IDLE
    do_reset();
    loop_mode = 1'b0;
    max_index = AW'(3);
    start_pass();
    model_req(d, i);
    @(posedge dataclk); #1 bus.cmd_req = 1'b1;
    @(posedge dataclk); #1 bus.cmd_req = 1'b0;
    enable = 1'b0;
    @(posedge dataclk); #1;
    @(posedge dataclk); #1;
    check("endrop_valid", bus.cmd_valid, 1);
    check("endrop_idle", busy, 0);
    @(posedge dataclk); #1;
    check("endrop_queue_drained", exp_q.size(), 0);

    // reset during CAPT kills the in-flight command
    do_reset();
    loop_mode = 1'b0;
    max_index = AW'(3);
    start_pass();
    issue_req();
    @(posedge dataclk); #1 bus.cmd_req = 1'b1;
    @(posedge dataclk); #1 bus.cmd_req = 1'b0;
    @(posedge dataclk); #1 reset = 1'b1;
    @(posedge dataclk); #1;
    check("rstcapt_valid", bus.cmd_valid, 0);
    check("rstcapt_word", bus.cmd_word, 0);
    check("rstcapt_index", bus.cmd_index, 0);
    check("rstcapt_addr", bus.RAM_addr_B, 0);
    check("rstcapt_busy", busy, 0);
    check("rstcapt_pd", bus.pass_done, 0);
    reset = 1'b0;
    check("rstcapt_queue_drained", exp_q.size(), 0);
    repeat (3) @(posedge dataclk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
